// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path and datapath: opcodes,
// mux select encodings, FSM states and the decoded opcode class.
package cpu_pkg;

    localparam logic [3:0] OP_MV   = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_CMP  = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_ST   = 4'd5;
    localparam logic [3:0] OP_MVHI = 4'd6;
    localparam logic [3:0] OP_JR   = 4'd8;
    localparam logic [3:0] OP_JZ   = 4'd9;
    localparam logic [3:0] OP_JN   = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd12;

    localparam logic [1:0] PC_SEL_ALU  = 2'd0;
    localparam logic [1:0] PC_SEL_RX   = 2'd1;
    localparam logic [1:0] PC_SEL_HOLD = 2'd2;

    localparam logic       ALU_A_RX = 1'b0;
    localparam logic       ALU_A_PC = 1'b1;

    localparam logic [2:0] ALU_B_IMM8  = 3'd0;
    localparam logic [2:0] ALU_B_RY    = 3'd1;
    localparam logic [2:0] ALU_B_IMM11 = 3'd2;

    localparam logic [1:0] RF_SEL_ALU = 2'd0;
    localparam logic [1:0] RF_SEL_MEM = 2'd1;
    localparam logic [1:0] RF_SEL_PC  = 2'd2;
    localparam logic [1:0] RF_SEL_OPB = 2'd3;

    localparam logic       MEM_SEL_PC = 1'b0;
    localparam logic       MEM_SEL_RY = 1'b1;

    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_LDWB   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_MV      = 3'd1,
        CLS_MVHI    = 3'd2,
        CLS_LD      = 3'd3,
        CLS_ST      = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_CALL    = 3'd6,
        CLS_ILLEGAL = 3'd7
    } op_class_e;

    // Condition for the jump family (jr/j, jz, jn); call is unconditional.
    function automatic logic jump_taken(input logic [3:0] op, input logic z, input logic n);
        return (op == OP_JR) || ((op == OP_JZ) && z) || ((op == OP_JN) && n);
    endfunction

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: splits the low IR byte into the fields
// the control FSM needs and classifies the opcode.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [7:0] ir_low,
    output logic [3:0] opcode,
    output logic       imm_flag,
    output logic [2:0] rx,
    output op_class_e  op_class
);

    assign opcode   = ir_low[3:0];
    assign imm_flag = ir_low[4];
    assign rx       = ir_low[7:5];

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_CMP: op_class = CLS_ALU;
            OP_MV:                  op_class = CLS_MV;
            OP_MVHI:                op_class = CLS_MVHI;
            OP_LD:                  op_class = CLS_LD;
            OP_ST:                  op_class = CLS_ST;
            OP_JR, OP_JZ, OP_JN:    op_class = CLS_JUMP;
            OP_CALL:                op_class = CLS_CALL;
            default:                op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Multi-cycle CPU control FSM: FETCH -> DECODE -> EXEC (-> LDWB for loads),
// producing datapath selects, register/flag enables and memory strobes.
module cpu_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir_out,
    input  logic        z,
    input  logic        n,
    input  logic        i_mem_wait,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic        o_retire,
    output logic        o_illegal,
    output logic        pc_inc,
    output logic [1:0]  pc_mux_sel,
    output logic        ir_enable,
    output logic        alu_sub,
    output logic        alu_mux_a_sel,
    output logic [2:0]  alu_mux_b_sel,
    output logic [2:0]  rf_w_addr,
    output logic        rf_write_en,
    output logic        rf_only_high,
    output logic [1:0]  rf_mux_sel,
    output logic        mem_mux_sel,
    output logic        z_en,
    output logic        n_en
);

    state_e    state_reg;
    logic [3:0] opcode;
    logic       imm_flag;
    logic [2:0] rx;
    op_class_e  op_class;
    logic       take_target;

    // Operand fields beyond Rx are consumed only by the datapath.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_out[15:8];

    cpu_decode u_decode (
        .ir_low   (ir_out[7:0]),
        .opcode   (opcode),
        .imm_flag (imm_flag),
        .rx       (rx),
        .op_class (op_class)
    );

    assign take_target = (op_class == CLS_CALL) ||
                         ((op_class == CLS_JUMP) && jump_taken(opcode, z, n));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            case (state_reg)
                ST_FETCH:  if (!i_mem_wait) state_reg <= ST_DECODE;
                ST_DECODE: state_reg <= ST_EXEC;
                ST_EXEC: begin
                    if (op_class == CLS_LD) begin
                        if (!i_mem_wait) state_reg <= ST_LDWB;
                    end else if (op_class == CLS_ST) begin
                        if (!i_mem_wait) state_reg <= ST_FETCH;
                    end else begin
                        state_reg <= ST_FETCH;
                    end
                end
                ST_LDWB:   state_reg <= ST_FETCH;
                default:   state_reg <= ST_FETCH;
            endcase
        end
    end

    // EXEC controls depend on the IR, which is only loaded as DECODE ends, so
    // outputs are decoded from the state register rather than registered.
    // Gating with rst makes a reset drop every strobe and enable at once.
    always_comb begin
        o_mem_rd      = 1'b0;
        o_mem_wr      = 1'b0;
        o_retire      = 1'b0;
        o_illegal     = 1'b0;
        pc_inc        = 1'b0;
        pc_mux_sel    = PC_SEL_HOLD;
        ir_enable     = 1'b0;
        alu_sub       = 1'b0;
        alu_mux_a_sel = ALU_A_RX;
        alu_mux_b_sel = ALU_B_IMM8;
        rf_w_addr     = 3'd0;
        rf_write_en   = 1'b0;
        rf_only_high  = 1'b0;
        rf_mux_sel    = RF_SEL_MEM;
        mem_mux_sel   = MEM_SEL_RY;
        z_en          = 1'b0;
        n_en          = 1'b0;
        if (!rst) begin
            case (state_reg)
                ST_FETCH: begin
                    o_mem_rd    = 1'b1;
                    mem_mux_sel = MEM_SEL_PC;
                end
                ST_DECODE: begin
                    ir_enable = 1'b1;
                    pc_inc    = 1'b1;
                end
                ST_EXEC: begin
                    case (op_class)
                        CLS_ALU: begin
                            alu_mux_b_sel = imm_flag ? ALU_B_IMM8 : ALU_B_RY;
                            alu_sub       = (opcode != OP_ADD);
                            z_en          = 1'b1;
                            n_en          = 1'b1;
                            if (opcode != OP_CMP) begin
                                rf_mux_sel  = RF_SEL_ALU;
                                rf_w_addr   = rx;
                                rf_write_en = 1'b1;
                            end
                            o_retire = 1'b1;
                        end
                        CLS_MV: begin
                            alu_mux_b_sel = imm_flag ? ALU_B_IMM8 : ALU_B_RY;
                            rf_mux_sel    = RF_SEL_OPB;
                            rf_w_addr     = rx;
                            rf_write_en   = 1'b1;
                            o_retire      = 1'b1;
                        end
                        CLS_MVHI: begin
                            alu_mux_b_sel = ALU_B_IMM8;
                            rf_mux_sel    = RF_SEL_OPB;
                            rf_w_addr     = rx;
                            rf_only_high  = 1'b1;
                            rf_write_en   = 1'b1;
                            o_retire      = 1'b1;
                        end
                        CLS_LD: begin
                            o_mem_rd    = 1'b1;
                            mem_mux_sel = MEM_SEL_RY;
                        end
                        CLS_ST: begin
                            o_mem_wr    = 1'b1;
                            mem_mux_sel = MEM_SEL_RY;
                            o_retire    = !i_mem_wait;
                        end
                        CLS_JUMP, CLS_CALL: begin
                            if (take_target) begin
                                if (imm_flag) begin
                                    alu_mux_a_sel = ALU_A_PC;
                                    alu_mux_b_sel = ALU_B_IMM11;
                                    pc_mux_sel    = PC_SEL_ALU;
                                end else begin
                                    pc_mux_sel = PC_SEL_RX;
                                end
                            end
                            if (op_class == CLS_CALL) begin
                                rf_mux_sel  = RF_SEL_PC;
                                rf_w_addr   = LINK_REG;
                                rf_write_en = 1'b1;
                            end
                            o_retire = 1'b1;
                        end
                        default: begin
                            o_illegal = 1'b1;
                            o_retire  = 1'b1;
                        end
                    endcase
                end
                ST_LDWB: begin
                    rf_mux_sel  = RF_SEL_MEM;
                    rf_w_addr   = rx;
                    rf_write_en = 1'b1;
                    o_retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: each instruction pushes its expected
// per-cycle control vectors, which are popped and compared cycle by cycle.
module tb_cpu_control;

    logic        clk;
    logic        rst;
    logic [15:0] ir_out;
    logic        z;
    logic        n;
    logic        i_mem_wait;
    logic        o_mem_rd, o_mem_wr, o_retire, o_illegal;
    logic        pc_inc;
    logic [1:0]  pc_mux_sel;
    logic        ir_enable, alu_sub, alu_mux_a_sel;
    logic [2:0]  alu_mux_b_sel;
    logic [2:0]  rf_w_addr;
    logic        rf_write_en, rf_only_high;
    logic [1:0]  rf_mux_sel;
    logic        mem_mux_sel, z_en, n_en;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       retire;
        logic       illegal;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_en;
        logic       sub;
        logic       a_sel;
        logic [2:0] b_sel;
        logic [2:0] w_addr;
        logic       we;
        logic       only_high;
        logic [1:0] rf_sel;
        logic       mem_sel;
        logic       z_en;
        logic       n_en;
    } ctl_t;

    typedef struct packed {
        ctl_t exp;
        logic wait_in;
    } step_t;

    step_t sb_q[$];
    int    cmp_count = 0;
    int    err_count = 0;

    cpu_control dut (
        .clk           (clk),
        .rst           (rst),
        .ir_out        (ir_out),
        .z             (z),
        .n             (n),
        .i_mem_wait    (i_mem_wait),
        .o_mem_rd      (o_mem_rd),
        .o_mem_wr      (o_mem_wr),
        .o_retire      (o_retire),
        .o_illegal     (o_illegal),
        .pc_inc        (pc_inc),
        .pc_mux_sel    (pc_mux_sel),
        .ir_enable     (ir_enable),
        .alu_sub       (alu_sub),
        .alu_mux_a_sel (alu_mux_a_sel),
        .alu_mux_b_sel (alu_mux_b_sel),
        .rf_w_addr     (rf_w_addr),
        .rf_write_en   (rf_write_en),
        .rf_only_high  (rf_only_high),
        .rf_mux_sel    (rf_mux_sel),
        .mem_mux_sel   (mem_mux_sel),
        .z_en          (z_en),
        .n_en          (n_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t c;
        c.mem_rd    = o_mem_rd;
        c.mem_wr    = o_mem_wr;
        c.retire    = o_retire;
        c.illegal   = o_illegal;
        c.pc_inc    = pc_inc;
        c.pc_sel    = pc_mux_sel;
        c.ir_en     = ir_enable;
        c.sub       = alu_sub;
        c.a_sel     = alu_mux_a_sel;
        c.b_sel     = alu_mux_b_sel;
        c.w_addr    = rf_w_addr;
        c.we        = rf_write_en;
        c.only_high = rf_only_high;
        c.rf_sel    = rf_mux_sel;
        c.mem_sel   = mem_mux_sel;
        c.z_en      = z_en;
        c.n_en      = n_en;
        return c;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t c = '0;
        c.pc_sel  = 2'd2;
        c.rf_sel  = 2'd1;
        c.mem_sel = 1'b1;
        return c;
    endfunction

    function automatic ctl_t fetch_ctl();
        ctl_t c = idle_ctl();
        c.mem_rd  = 1'b1;
        c.mem_sel = 1'b0;
        return c;
    endfunction

    function automatic ctl_t decode_ctl();
        ctl_t c = idle_ctl();
        c.ir_en  = 1'b1;
        c.pc_inc = 1'b1;
        return c;
    endfunction

    // Reference behaviour of one EXEC cycle.
    function automatic ctl_t exec_ctl(input logic [15:0] ir, input logic zz, input logic nn,
                                      input logic wt);
        ctl_t       c = idle_ctl();
        logic [3:0] op = ir[3:0];
        logic       imm = ir[4];
        logic [2:0] rx = ir[7:5];
        logic       taken;
        case (op)
            4'd0: begin
                c.b_sel = imm ? 3'd0 : 3'd1; c.rf_sel = 2'd3; c.w_addr = rx; c.we = 1'b1;
                c.retire = 1'b1;
            end
            4'd1, 4'd2: begin
                c.b_sel = imm ? 3'd0 : 3'd1; c.sub = (op == 4'd2); c.rf_sel = 2'd0;
                c.w_addr = rx; c.we = 1'b1; c.z_en = 1'b1; c.n_en = 1'b1; c.retire = 1'b1;
            end
            4'd3: begin
                c.b_sel = imm ? 3'd0 : 3'd1; c.sub = 1'b1; c.z_en = 1'b1; c.n_en = 1'b1;
                c.retire = 1'b1;
            end
            4'd4: begin
                c.mem_rd = 1'b1; c.mem_sel = 1'b1;
            end
            4'd5: begin
                c.mem_wr = 1'b1; c.mem_sel = 1'b1; c.retire = !wt;
            end
            4'd6: begin
                c.rf_sel = 2'd3; c.b_sel = 3'd0; c.only_high = 1'b1; c.we = 1'b1;
                c.w_addr = rx; c.retire = 1'b1;
            end
            4'd8, 4'd9, 4'd10, 4'd12: begin
                taken = (op == 4'd8) || (op == 4'd12) || (op == 4'd9 && zz) || (op == 4'd10 && nn);
                if (taken && imm) begin
                    c.a_sel = 1'b1; c.b_sel = 3'd2; c.pc_sel = 2'd0;
                end else if (taken) begin
                    c.pc_sel = 2'd1;
                end
                if (op == 4'd12) begin
                    c.rf_sel = 2'd2; c.w_addr = 3'd7; c.we = 1'b1;
                end
                c.retire = 1'b1;
            end
            default: begin
                c.illegal = 1'b1; c.retire = 1'b1;
            end
        endcase
        return c;
    endfunction

    function automatic step_t mk(input ctl_t c, input logic w);
        step_t s;
        s.exp     = c;
        s.wait_in = w;
        return s;
    endfunction

    // Called at posedge+1 with the FSM in FETCH; fw/ew are stall cycles.
    task automatic run_instr(input string name, input logic [15:0] ir, input logic zz,
                             input logic nn, input int fw, input int ew, input int lat);
        step_t    s;
        ctl_t     ldwb;
        int       cyc = 0;
        int       retire_at = 0;
        logic [3:0] op = ir[3:0];
        sb_q.delete();
        for (int i = 0; i < fw; i++) sb_q.push_back(mk(fetch_ctl(), 1'b1));
        sb_q.push_back(mk(fetch_ctl(), 1'b0));
        sb_q.push_back(mk(decode_ctl(), 1'b0));
        if (op == 4'd4 || op == 4'd5) begin
            for (int i = 0; i < ew; i++) sb_q.push_back(mk(exec_ctl(ir, zz, nn, 1'b1), 1'b1));
        end
        sb_q.push_back(mk(exec_ctl(ir, zz, nn, 1'b0), 1'b0));
        if (op == 4'd4) begin
            ldwb = idle_ctl();
            ldwb.rf_sel = 2'd1; ldwb.w_addr = ir[7:5]; ldwb.we = 1'b1; ldwb.retire = 1'b1;
            sb_q.push_back(mk(ldwb, 1'b0));
        end
        ir_out = ir;
        z = zz;
        n = nn;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            i_mem_wait = s.wait_in;
            @(negedge clk);
            cyc++;
            if (o_retire && retire_at == 0) retire_at = cyc;
            check($sformatf("%s_c%0d", name, cyc), 32'(observed()), 32'(s.exp));
            @(posedge clk);
            #1;
        end
        i_mem_wait = 1'b0;
        check({name, "_lat"}, 32'(retire_at), 32'(lat));
        $display("instr %-10s ir=%h z=%0d n=%0d cycles=%0d retire_at=%0d", name, ir, zz, nn,
                 cyc, retire_at);
    endtask

    initial begin
        rst = 1'b1;
        ir_out = 16'h0000;
        z = 1'b0;
        n = 1'b0;
        i_mem_wait = 1'b0;
        @(negedge clk);
        check("reset_idle", 32'(observed()), 32'(idle_ctl()));
        i_mem_wait = 1'b1;
        @(negedge clk);
        check("reset_idle_wait", 32'(observed()), 32'(idle_ctl()));
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_mem_wait = 1'b0;

        run_instr("addi",      16'h8C51, 1'b0, 1'b0, 0, 0, 3);
        run_instr("add_reg",   16'h0561, 1'b0, 1'b0, 0, 0, 3);
        run_instr("subi",      16'h0352, 1'b0, 1'b0, 0, 0, 3);
        run_instr("cmp_reg",   16'h0283, 1'b0, 1'b0, 0, 0, 3);
        run_instr("mvi",       16'h7FF0, 1'b0, 1'b0, 0, 0, 3);
        run_instr("mvhi",      16'hAB36, 1'b0, 1'b0, 0, 0, 3);
        run_instr("ld",        16'h0324, 1'b0, 1'b0, 0, 0, 4);
        run_instr("ld_wait",   16'h0324, 1'b0, 1'b0, 0, 2, 6);
        run_instr("ld_fstall", 16'h0344, 1'b0, 1'b0, 1, 0, 5);
        run_instr("st_wait",   16'h0445, 1'b0, 1'b0, 0, 1, 4);
        run_instr("jz_imm_nt", 16'h1239, 1'b0, 1'b1, 0, 0, 3);
        run_instr("jz_imm_t",  16'h1239, 1'b1, 1'b0, 0, 0, 3);
        run_instr("jn_reg_t",  16'h00AA, 1'b0, 1'b1, 0, 0, 3);
        run_instr("jn_reg_nt", 16'h00AA, 1'b1, 1'b0, 0, 0, 3);
        run_instr("j_reg",     16'h0068, 1'b0, 1'b0, 0, 0, 3);
        run_instr("call_reg",  16'h002C, 1'b0, 1'b0, 0, 0, 3);
        run_instr("call_imm",  16'h4F3C, 1'b0, 1'b0, 0, 0, 3);
        run_instr("illegal_f", 16'h000F, 1'b0, 1'b0, 0, 0, 3);
        run_instr("illegal_7", 16'h0007, 1'b1, 1'b1, 0, 0, 3);
        run_instr("illegal_b", 16'h001B, 1'b0, 1'b0, 0, 0, 3);

        // Reset asserted while a store is stalled in EXEC.
        ir_out = 16'h0445;
        @(negedge clk);
        check("rst_st_fetch", 32'(observed()), 32'(fetch_ctl()));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_st_decode", 32'(observed()), 32'(decode_ctl()));
        @(posedge clk);
        #1;
        i_mem_wait = 1'b1;
        @(negedge clk);
        check("rst_st_wr", 32'(o_mem_wr), 32'(1));
        #1;
        rst = 1'b1;
        #1;
        check("rst_st_wr_drop", 32'(observed()), 32'(idle_ctl()));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_st_held", 32'(observed()), 32'(idle_ctl()));
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_mem_wait = 1'b0;
        run_instr("after_rst", 16'h8C51, 1'b0, 1'b0, 0, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
